// File: rtl/idli_sqi_fetch_m.sv
// SQI instruction fetch: issues a sequential read (cmd, 24b address, dummy) and
// packs the nibble stream into 16b words behind a valid/accept output register.
module idli_sqi_fetch_m #(
  parameter int          ADDR_W    = 16,
  parameter logic [7:0]  RD_CMD    = 8'h03,
  parameter int          DUMMY_NIB = 2
) (
  input  logic              i_fetch_gck,
  input  logic              i_ex_rst_n,
  output logic              o_sqi_cs_n,
  output logic              o_sqi_oe,
  output logic [3:0]        o_sqi_sio,
  input  logic [3:0]        i_sqi_sio,
  input  logic              i_fetch_redir,
  input  logic [ADDR_W-1:0] i_fetch_redir_pc,
  output logic [15:0]       o_fetch_instr,
  output logic [ADDR_W-1:0] o_fetch_pc,
  output logic              o_fetch_vld,
  input  logic              i_fetch_acp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA
  } state_t;

  localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_NIB - 1);

  state_t            state_q, state_d;
  logic [2:0]        ph_q, ph_d;
  logic [1:0]        nib_q, nib_d;
  logic [11:0]       part_q, part_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] opc_q, opc_d;
  logic [15:0]       instr_q, instr_d;
  logic              vld_q, vld_d;

  logic [23:0]       baddr;
  logic [15:0]       word;
  logic              cs_n;
  logic              oe;
  logic [3:0]        sio;

  // Word address -> byte address of its low byte
  assign baddr = {{(23-ADDR_W){1'b0}}, pc_q, 1'b0};

  // Nibbles arrive as [7:4], [3:0], [15:12], [11:8]; the last one is still on the bus
  assign word = {part_q[3:0], i_sqi_sio, part_q[11:8], part_q[7:4]};

  always_ff @(posedge i_fetch_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_fetch_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      ph_q    <= '0;
      nib_q   <= '0;
      part_q  <= '0;
      pc_q    <= '0;
      opc_q   <= '0;
      instr_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      nib_q   <= nib_d;
      part_q  <= part_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q + 3'd1;
    nib_d   = nib_q;
    part_d  = part_q;
    pc_d    = pc_q;
    opc_d   = opc_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    cs_n    = 1'b1;
    oe      = 1'b0;
    sio     = 4'h0;

    if (vld_q && i_fetch_acp) begin
      vld_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_CMD;
        ph_d    = '0;
        nib_d   = '0;
      end
      S_CMD: begin
        cs_n = 1'b0;
        oe   = 1'b1;
        sio  = ph_q[0] ? RD_CMD[3:0] : RD_CMD[7:4];
        if (ph_q == 3'd1) begin
          state_d = S_ADDR;
          ph_d    = '0;
        end
      end
      S_ADDR: begin
        cs_n = 1'b0;
        oe   = 1'b1;
        case (ph_q)
          3'd0:    sio = baddr[23:20];
          3'd1:    sio = baddr[19:16];
          3'd2:    sio = baddr[15:12];
          3'd3:    sio = baddr[11:8];
          3'd4:    sio = baddr[7:4];
          3'd5:    sio = baddr[3:0];
          default: sio = 4'h0;
        endcase
        if (ph_q == 3'd5) begin
          state_d = S_DUMMY;
          ph_d    = '0;
        end
      end
      S_DUMMY: begin
        cs_n = 1'b0;
        if (ph_q == DUMMY_LAST) begin
          state_d = S_DATA;
          ph_d    = '0;
          nib_d   = '0;
        end
      end
      S_DATA: begin
        cs_n   = 1'b0;
        ph_d   = '0;
        nib_d  = nib_q + 2'd1;
        part_d = {part_q[7:0], i_sqi_sio};
        if (nib_q == 2'd3) begin
          if (!vld_q || i_fetch_acp) begin
            instr_d = word;
            opc_d   = pc_q;
            vld_d   = 1'b1;
            pc_d    = pc_q + 1'b1;
          end else begin
            // Output still full: drop this word and re-read it from its own address
            state_d = S_IDLE;
            nib_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
        nib_d   = '0;
      end
    endcase

    if (i_fetch_redir) begin
      state_d = S_IDLE;
      ph_d    = '0;
      nib_d   = '0;
      pc_d    = i_fetch_redir_pc;
      vld_d   = 1'b0;
    end
  end

  assign o_sqi_cs_n    = cs_n;
  assign o_sqi_oe      = oe;
  assign o_sqi_sio     = sio;
  assign o_fetch_instr = instr_q;
  assign o_fetch_pc    = opc_q;
  assign o_fetch_vld   = vld_q;

endmodule

// File: tb/tb_idli_sqi_fetch_m.sv
// Bench for idli_sqi_fetch_m: SQI memory slave model, scoreboard of expected
// fetched words, cycle-exact directed scenarios and a randomized run.
module tb_idli_sqi_fetch_m;

  logic        clk;
  logic        rst_n;
  logic        cs_n;
  logic        oe;
  logic [3:0]  sio_out;
  logic [3:0]  sio_in;
  logic        redir;
  logic [15:0] redir_pc;
  logic [15:0] instr;
  logic [15:0] opc;
  logic        vld;
  logic        acp;

  int total = 0;
  int bad   = 0;
  int xfers = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  idli_sqi_fetch_m #(.ADDR_W(16), .RD_CMD(8'h03), .DUMMY_NIB(2)) dut (
    .i_fetch_gck      (clk),
    .i_ex_rst_n       (rst_n),
    .o_sqi_cs_n       (cs_n),
    .o_sqi_oe         (oe),
    .o_sqi_sio        (sio_out),
    .i_sqi_sio        (sio_in),
    .i_fetch_redir    (redir),
    .i_fetch_redir_pc (redir_pc),
    .o_fetch_instr    (instr),
    .o_fetch_pc       (opc),
    .o_fetch_vld      (vld),
    .i_fetch_acp      (acp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memw(input logic [15:0] a);
    case (a)
      16'h0000: memw = 16'h1234;
      16'h0001: memw = 16'hABCD;
      16'h0002: memw = 16'h0F0F;
      default:  memw = (a * 16'h9E37) ^ 16'h5A5A ^ {a[7:0], a[15:8]};
    endcase
  endfunction

  // Memory is byte addressed; word A = {byte 2A+1, byte 2A}, high nibble of each byte first
  function automatic logic [3:0] mem_nib(input logic [23:0] ba0, input int n);
    logic [23:0] ba;
    logic [15:0] w;
    logic [7:0]  b;
    ba = ba0 + 24'(n / 2);
    w  = memw(ba[16:1]);
    b  = ba[0] ? w[15:8] : w[7:0];
    return (n % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_from(input logic [15:0] pc0);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 1100; i++) begin
      e.pc    = pc0 + 16'(i);
      e.instr = memw(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redir = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst cs_n", cs_n, 1);
    chk("rst oe", oe, 0);
    chk("rst sio", sio_out, 0);
    chk("rst vld", vld, 0);
    chk("rst instr", instr, 0);
    chk("rst pc", opc, 0);
    push_from(16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // SQI slave: decodes cmd/address from the bus and streams data after the dummy phase
  int          scnt;
  logic [7:0]  scmd;
  logic [23:0] saddr;
  always @(negedge clk) begin
    if (cs_n) begin
      scnt   = 0;
      scmd   = '0;
      saddr  = '0;
      sio_in = 4'h0;
    end else begin
      if (scnt < 2) begin
        scmd = {scmd[3:0], sio_out};
        if (scnt == 1) chk("slave cmd byte", scmd, 8'h03);
      end else if (scnt < 8) begin
        saddr = {saddr[19:0], sio_out};
      end
      if (scnt < 8) chk("slave oe drive", oe, 1);
      else          chk("slave oe release", oe, 0);
      sio_in = (scnt >= 10) ? mem_nib(saddr, scnt - 10) : 4'h0;
      scnt++;
    end
  end

  // Monitor: every transfer must be the next word of the sequential stream
  logic        hold_p;
  logic [15:0] hold_instr;
  logic [15:0] hold_pc;
  initial hold_p = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_p = 1'b0;
    end else begin
      if (hold_p && vld) begin
        chk("held instr stable", instr, hold_instr);
        chk("held pc stable", opc, hold_pc);
      end
      if (vld && acp && !redir) begin
        xfers++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL xfer unexpected: got pc %0h instr %0h want none", opc, instr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("xfer pc", opc, mon_e.pc);
          chk("xfer instr", instr, mon_e.instr);
        end
      end
      hold_p     = vld && !acp && !redir;
      hold_instr = instr;
      hold_pc    = opc;
    end
  end

  initial begin
    rst_n    = 1'b0;
    redir    = 1'b0;
    redir_pc = '0;
    acp      = 1'b1;

    // Reset release, first word latency, then a continuous stream
    do_reset();
    for (int k = 0; k <= 23; k++) begin
      acp = 1'b1;
      @(negedge clk);
      chk("t1 cs_n", cs_n, (k == 0));
      if (k >= 1 && k <= 8) begin
        chk("t1 oe", oe, 1);
        chk("t1 sio", sio_out, (k == 2) ? 3 : 0);
      end else begin
        chk("t1 oe", oe, 0);
        chk("t1 sio", sio_out, 0);
      end
      chk("t1 vld", vld, (k >= 15 && (k - 15) % 4 == 0));
      if (k == 15) begin chk("t1 instr0", instr, 16'h1234); chk("t1 pc0", opc, 0); end
      if (k == 19) begin chk("t1 instr1", instr, 16'hABCD); chk("t1 pc1", opc, 1); end
      if (k == 23) begin chk("t1 instr2", instr, 16'h0F0F); chk("t1 pc2", opc, 2); end
      @(posedge clk);
      #1;
    end

    // Stalled output: overflow drops word 1 and re-reads it from byte 0x000002
    acp = 1'b0;
    do_reset();
    for (int k = 0; k <= 35; k++) begin
      acp = (k >= 23);
      @(negedge clk);
      chk("t3 cs_n", cs_n, (k == 0 || k == 19));
      if (k >= 22 && k <= 27) chk("t3 addr nib", sio_out, (k == 27) ? 2 : 0);
      if (k >= 15 && k <= 23) begin
        chk("t3 vld held", vld, 1);
        chk("t3 instr held", instr, 16'h1234);
        chk("t3 pc held", opc, 0);
      end
      if (k >= 24 && k <= 33) chk("t3 vld gap", vld, 0);
      if (k == 34) begin
        chk("t3 vld restart", vld, 1);
        chk("t3 pc restart", opc, 1);
        chk("t3 instr restart", instr, 16'hABCD);
      end
      @(posedge clk);
      #1;
    end

    // Redirect to 0x0100 on nibble 2 of word 1 while word 0 is held
    acp = 1'b0;
    do_reset();
    for (int k = 0; k <= 33; k++) begin
      acp      = (k >= 18);
      redir    = (k == 17);
      redir_pc = 16'h0100;
      if (k == 17) push_from(16'h0100);
      @(negedge clk);
      chk("t4 cs_n", cs_n, (k == 0 || k == 18));
      if (k >= 21 && k <= 26) chk("t4 addr nib", sio_out, (k == 24) ? 2 : 0);
      if (k >= 15 && k <= 17) chk("t4 vld before", vld, 1);
      if (k >= 18 && k <= 32) chk("t4 vld cleared", vld, 0);
      if (k == 33) begin
        chk("t4 vld target", vld, 1);
        chk("t4 pc target", opc, 16'h0100);
        chk("t4 instr target", instr, memw(16'h0100));
      end
      @(posedge clk);
      #1;
    end
    redir = 1'b0;

    // Redirect on the completion cycle of word 0 with acp high
    acp = 1'b1;
    do_reset();
    for (int k = 0; k <= 30; k++) begin
      redir    = (k == 14);
      redir_pc = 16'h0040;
      if (k == 14) push_from(16'h0040);
      @(negedge clk);
      chk("t5 cs_n", cs_n, (k == 0 || k == 15));
      if (k >= 18 && k <= 23) chk("t5 addr nib", sio_out, (k == 22) ? 8 : 0);
      chk("t5 vld", vld, (k == 30));
      if (k == 30) begin
        chk("t5 pc target", opc, 16'h0040);
        chk("t5 instr target", instr, memw(16'h0040));
      end
      @(posedge clk);
      #1;
    end
    redir = 1'b0;

    // Asynchronous reset during the address phase
    do_reset();
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("t6 cs_n in addr", cs_n, 0);
    chk("t6 oe in addr", oe, 1);
    rst_n = 1'b0;
    #1;
    chk("t6 cs_n async", cs_n, 1);
    chk("t6 oe async", oe, 0);
    do_reset();
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      chk("t6 cs_n", cs_n, (k == 0));
      chk("t6 vld", vld, (k == 15));
      if (k == 15) begin
        chk("t6 pc", opc, 0);
        chk("t6 instr", instr, 16'h1234);
      end
      @(posedge clk);
      #1;
    end

    // Randomized accept and redirects, including targets that wrap the pc
    do_reset();
    xfers = 0;
    for (int c = 0; c < 4000; c++) begin
      acp   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 149) == 0);
      if (redir) begin
        if ($urandom_range(0, 3) == 0) redir_pc = 16'hFFFC + 16'($urandom_range(0, 3));
        else                           redir_pc = 16'($urandom);
        push_from(redir_pc);
      end
      @(posedge clk);
      #1;
    end
    redir = 1'b0;
    chk("random transfers seen", (xfers > 200), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
